// File: rtl/s32x_fb_arbiter_pkg.sv
// Shared types for the 32X framebuffer draw-port arbiter: posted-write payload,
// arbiter FSM states and the fill byte-enable constant.
package s32x_fb_arbiter_pkg;

  localparam int unsigned FB_AW = 16;
  localparam int unsigned FB_DW = 16;

  localparam logic [1:0] FB_FILL_WE = 2'b11;

  typedef struct packed {
    logic [FB_AW-1:0] a;
    logic [FB_DW-1:0] d;
    logic [1:0]       we;
  } fb_wreq_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_ISSUE,
    RD_WAIT,
    FILL
  } fb_arb_state_t;

endpackage

// File: rtl/s32x_fb_wfifo.sv
// Posted-write FIFO of fb_wreq_t entries; head entry is visible on rdata while not empty.
module s32x_fb_wfifo
  import s32x_fb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     push,
  input  fb_wreq_t wdata,
  input  logic     pop,
  output fb_wreq_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fb_wreq_t        mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Extra pointer MSB distinguishes full from empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/s32x_fb_arbiter.sv
// Shares the 32X framebuffer draw port between SH2 reads, posted SH2 writes and the auto-fill engine.
// Overwrite-region byte suppression is built when S32X_FB_OVERWRITE_EN is defined.
module s32x_fb_arbiter
  import s32x_fb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FB_RD_LAT  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        FB_GNT,
  input  logic        CPU_REQ,
  input  logic        CPU_RD,
  input  logic [15:0] CPU_A,
  input  logic        CPU_OVW,
  input  logic [15:0] CPU_DI,
  input  logic [1:0]  CPU_BE,
  output logic [15:0] CPU_DO,
  output logic        CPU_ACK,
  input  logic        FILL_START,
  input  logic [7:0]  FILL_LEN,
  input  logic [15:0] FILL_ADDR,
  input  logic [15:0] FILL_DATA,
  output logic        FILL_BUSY,
  output logic [15:0] FILL_AOUT,
  output logic [15:0] FB_A,
  output logic [15:0] FB_D,
  output logic [1:0]  FB_WE,
  input  logic [15:0] FB_Q,
  output logic        WF_FULL,
  output logic        WF_EMPTY
);

  localparam int unsigned RD_CW = (FB_RD_LAT > 1) ? $clog2(FB_RD_LAT) : 1;

  fb_arb_state_t    state;
  fb_arb_state_t    state_nxt;
  fb_wreq_t         wf_head;
  fb_wreq_t         wf_wdata;
  logic             wf_push;
  logic             wf_pop;
  logic [1:0]       wr_we;
  logic             wr_accept;
  logic             rd_req;
  logic             rd_issue;
  logic             rd_done;
  logic             fill_fire;
  logic             fill_last;
  logic [RD_CW-1:0] rd_cnt;
  logic [15:0]      rd_addr;
  logic [15:0]      fill_data;
  logic [7:0]       fill_rem;

`ifdef S32X_FB_OVERWRITE_EN
  // Overwrite region: zero bytes are transparent and must not be written.
  always_comb begin
    wr_we = CPU_BE;
    if (CPU_OVW) wr_we = {CPU_BE[1] & (|CPU_DI[15:8]), CPU_BE[0] & (|CPU_DI[7:0])};
  end
`else
  logic ovw_unused;
  assign ovw_unused = CPU_OVW;
  assign wr_we      = CPU_BE;
`endif

  assign rd_req    = CPU_REQ & ~CPU_ACK & CPU_RD;
  assign wr_accept = CPU_REQ & ~CPU_ACK & ~CPU_RD & ~WF_FULL & ~FILL_BUSY;
  assign wf_push   = wr_accept & (|wr_we);
  assign wf_wdata  = '{a: CPU_A, d: CPU_DI, we: wr_we};
  assign fill_last = fill_fire & (fill_rem == 8'd0);

  s32x_fb_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (wf_push),
    .wdata (wf_wdata),
    .pop   (wf_pop),
    .rdata (wf_head),
    .full  (WF_FULL),
    .empty (WF_EMPTY)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Posted writes drain before fills, fills before reads, so reads see all prior writes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!WF_EMPTY)      state_nxt = DRAIN;
        else if (FILL_BUSY) state_nxt = FILL;
        else if (rd_req)    state_nxt = RD_ISSUE;
      end
      DRAIN:    if (WF_EMPTY) state_nxt = IDLE;
      RD_ISSUE: if (rd_issue) state_nxt = RD_WAIT;
      RD_WAIT:  if (rd_done)  state_nxt = IDLE;
      FILL:     if (!FILL_BUSY || (fill_last && !FILL_START)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    FB_A      = '0;
    FB_D      = '0;
    FB_WE     = '0;
    wf_pop    = 1'b0;
    fill_fire = 1'b0;
    rd_issue  = 1'b0;
    rd_done   = 1'b0;
    unique case (state)
      DRAIN: if (FB_GNT && !WF_EMPTY) begin
        wf_pop = 1'b1;
        FB_A   = wf_head.a;
        FB_D   = wf_head.d;
        FB_WE  = wf_head.we;
      end
      RD_ISSUE: begin
        FB_A     = CPU_A;
        rd_issue = FB_GNT;
      end
      // Address held through the wait even if the grant drops.
      RD_WAIT: begin
        FB_A    = rd_addr;
        rd_done = (rd_cnt == RD_CW'(FB_RD_LAT - 1));
      end
      FILL: if (CE && FB_GNT) begin
        fill_fire = 1'b1;
        FB_A      = FILL_AOUT;
        FB_D      = fill_data;
        FB_WE     = FB_FILL_WE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CPU_DO    <= '0;
      CPU_ACK   <= 1'b0;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      FILL_BUSY <= 1'b0;
      FILL_AOUT <= '0;
      fill_data <= '0;
      fill_rem  <= '0;
    end else begin
      CPU_ACK <= CPU_REQ & (CPU_ACK | wr_accept | rd_done);
      if (rd_done) CPU_DO <= FB_Q;
      if (rd_issue) begin
        rd_addr <= CPU_A;
        rd_cnt  <= '0;
      end else if (state == RD_WAIT && !rd_done) begin
        rd_cnt <= rd_cnt + RD_CW'(1);
      end
      // A new start always wins, including over the final word of a running fill.
      if (FILL_START) begin
        FILL_BUSY <= 1'b1;
        FILL_AOUT <= FILL_ADDR;
        fill_data <= FILL_DATA;
        fill_rem  <= FILL_LEN;
      end else if (fill_fire) begin
        FILL_AOUT[7:0] <= FILL_AOUT[7:0] + 8'd1;
        if (fill_last) FILL_BUSY <= 1'b0;
        else           fill_rem  <= fill_rem - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_s32x_fb_arbiter.sv
// Scoreboard bench for s32x_fb_arbiter: expected FB writes and read data are queued at stimulus time
// and popped by a monitor whenever the DUT writes the FB or acks a read.
module tb_s32x_fb_arbiter;

  localparam int unsigned FB_RD_LAT = 1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  we;
  } exp_wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic        FB_GNT = 1'b0;
  logic        CPU_REQ = 1'b0;
  logic        CPU_RD = 1'b0;
  logic [15:0] CPU_A = '0;
  logic        CPU_OVW = 1'b0;
  logic [15:0] CPU_DI = '0;
  logic [1:0]  CPU_BE = '0;
  logic [15:0] CPU_DO;
  logic        CPU_ACK;
  logic        FILL_START = 1'b0;
  logic [7:0]  FILL_LEN = '0;
  logic [15:0] FILL_ADDR = '0;
  logic [15:0] FILL_DATA = '0;
  logic        FILL_BUSY;
  logic [15:0] FILL_AOUT;
  logic [15:0] FB_A;
  logic [15:0] FB_D;
  logic [1:0]  FB_WE;
  logic [15:0] FB_Q = '0;
  logic        WF_FULL;
  logic        WF_EMPTY;

  logic        ce_half = 1'b0;
  logic        ack_prev = 1'b0;
  logic [15:0] fb_mem [0:65535];
  exp_wr_t     exp_wr [$];
  logic [15:0] exp_rd [$];
  int          total = 0;
  int          bad = 0;

  s32x_fb_arbiter #(.FIFO_DEPTH(4), .FB_RD_LAT(FB_RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .FB_GNT(FB_GNT),
    .CPU_REQ(CPU_REQ), .CPU_RD(CPU_RD), .CPU_A(CPU_A), .CPU_OVW(CPU_OVW),
    .CPU_DI(CPU_DI), .CPU_BE(CPU_BE), .CPU_DO(CPU_DO), .CPU_ACK(CPU_ACK),
    .FILL_START(FILL_START), .FILL_LEN(FILL_LEN), .FILL_ADDR(FILL_ADDR), .FILL_DATA(FILL_DATA),
    .FILL_BUSY(FILL_BUSY), .FILL_AOUT(FILL_AOUT),
    .FB_A(FB_A), .FB_D(FB_D), .FB_WE(FB_WE), .FB_Q(FB_Q),
    .WF_FULL(WF_FULL), .WF_EMPTY(WF_EMPTY)
  );

  always #5 CLK = ~CLK;

  // Dot-clock strobe: every cycle, or every second cycle when ce_half is set.
  initial forever begin
    @(posedge CLK); #1;
    CE = ce_half ? ~CE : 1'b1;
  end

  // FB RAM with one cycle of read latency and byte writes.
  initial for (int i = 0; i < 65536; i++) fb_mem[i] = '0;
  always @(posedge CLK) begin
    if (FB_WE[1]) fb_mem[FB_A][15:8] <= FB_D[15:8];
    if (FB_WE[0]) fb_mem[FB_A][7:0]  <= FB_D[7:0];
    FB_Q <= fb_mem[FB_A];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every FB write and every read ack is matched against the scoreboard.
  always @(negedge CLK) begin
    if (FB_WE != 2'b00) begin
      check("fb_we_with_gnt", 64'(FB_GNT), 64'd1);
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fb_wr_unexpected: got a=%h d=%h we=%b expected no write (t=%0t)", FB_A, FB_D, FB_WE, $time);
      end else begin
        exp_wr_t e;
        e = exp_wr.pop_front();
        check("fb_wr", {30'd0, FB_A, FB_D, FB_WE}, {30'd0, e.a, e.d, e.we});
      end
    end
    if (CPU_ACK && !ack_prev && CPU_RD) begin
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %h expected no read ack (t=%0t)", CPU_DO, $time);
      end else begin
        check("cpu_rd_data", 64'(CPU_DO), 64'(exp_rd.pop_front()));
      end
    end
    ack_prev = CPU_ACK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic exp_push(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
    exp_wr_t e;
    e.a = a; e.d = d; e.we = we;
    exp_wr.push_back(e);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_cpu_do"},    64'(CPU_DO),    64'd0);
    check({pfx, "_cpu_ack"},   64'(CPU_ACK),   64'd0);
    check({pfx, "_fill_busy"}, 64'(FILL_BUSY), 64'd0);
    check({pfx, "_fill_aout"}, 64'(FILL_AOUT), 64'd0);
    check({pfx, "_fb_a"},      64'(FB_A),      64'd0);
    check({pfx, "_fb_d"},      64'(FB_D),      64'd0);
    check({pfx, "_fb_we"},     64'(FB_WE),     64'd0);
    check({pfx, "_wf_empty"},  64'(WF_EMPTY),  64'd1);
    check({pfx, "_wf_full"},   64'(WF_FULL),   64'd0);
  endtask

  // Write handshake; lat = edges until ack seen, busy_b = FILL_BUSY one sample before the ack.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                          input logic ovw, input int gnt_at, output int lat, output logic busy_b);
    lat = 0;
    busy_b = FILL_BUSY;
    CPU_REQ = 1'b1; CPU_RD = 1'b0; CPU_A = a; CPU_DI = d; CPU_BE = be; CPU_OVW = ovw;
    while (!CPU_ACK && lat < 60) begin
      if (lat == gnt_at) FB_GNT = 1'b1;
      busy_b = FILL_BUSY;
      tick();
      lat++;
    end
    check("wr_ack", 64'(CPU_ACK), 64'd1);
    CPU_REQ = 1'b0;
    tick();
    check("wr_ack_clear", 64'(CPU_ACK), 64'd0);
    CPU_OVW = 1'b0;
  endtask

  // Read handshake; issue_at = first sample presenting the read address with no write.
  task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input int gnt_at,
                         output int lat, output int issue_at);
    exp_rd.push_back(exp);
    lat = 0;
    issue_at = -1;
    CPU_REQ = 1'b1; CPU_RD = 1'b1; CPU_A = a;
    while (!CPU_ACK && lat < 60) begin
      if (lat == gnt_at) FB_GNT = 1'b1;
      if (issue_at < 0 && FB_A == a && FB_WE == 2'b00 && FB_GNT) issue_at = lat;
      tick();
      lat++;
    end
    check("rd_ack", 64'(CPU_ACK), 64'd1);
    CPU_REQ = 1'b0;
    tick();
    check("rd_ack_clear", 64'(CPU_ACK), 64'd0);
    CPU_RD = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!WF_EMPTY && n < 40) begin tick(); n++; end
    check("drain_empty", 64'(WF_EMPTY), 64'd1);
    tick(); tick();
  endtask

  initial begin
    int   lat;
    int   iss;
    int   n;
    logic bb;

    repeat (3) tick();
    check_reset("rst");
    RST = 1'b0;
    tick();

    // Fill across the low-byte wrap with CE every second cycle.
    FB_GNT = 1'b1;
    ce_half = 1'b1;
    exp_push(16'h12FE, 16'hA5A5, 2'b11);
    exp_push(16'h12FF, 16'hA5A5, 2'b11);
    exp_push(16'h1200, 16'hA5A5, 2'b11);
    exp_push(16'h1201, 16'hA5A5, 2'b11);
    FILL_ADDR = 16'h12FE; FILL_LEN = 8'd3; FILL_DATA = 16'hA5A5; FILL_START = 1'b1;
    tick();
    FILL_START = 1'b0;
    check("fill_busy_set", 64'(FILL_BUSY), 64'd1);
    check("fill_aout_load", 64'(FILL_AOUT), 64'h12FE);
    n = 0;
    while (FILL_BUSY && n < 60) begin tick(); n++; end
    check("fill_busy_clear", 64'(FILL_BUSY), 64'd0);
    check("fill_words_done", 64'(exp_wr.size()), 64'd0);
    check("fill_aout_end", 64'(FILL_AOUT), 64'h1202);
    ce_half = 1'b0;
    tick(); tick();

    // Ordering: three posted writes queued with no grant, then a read that must see them.
    FB_GNT = 1'b0;
    exp_push(16'h0010, 16'h1111, 2'b11);
    exp_push(16'h0011, 16'h2222, 2'b11);
    exp_push(16'h0012, 16'h3333, 2'b11);
    do_write(16'h0010, 16'h1111, 2'b11, 1'b0, -1, lat, bb);
    do_write(16'h0011, 16'h2222, 2'b11, 1'b0, -1, lat, bb);
    do_write(16'h0012, 16'h3333, 2'b11, 1'b0, -1, lat, bb);
    check("order_queued", 64'(exp_wr.size()), 64'd3);
    do_read(16'h0011, 16'h2222, 3, lat, iss);
    check("order_drained_first", 64'(exp_wr.size()), 64'd0);
    check("rd_latency", 64'(lat - iss), 64'(FB_RD_LAT + 1));
    tick();

    // FIFO full: four writes fill it with no grant, the fifth stalls until the first pop.
    FB_GNT = 1'b0;
    for (int i = 0; i < 5; i++) exp_push(16'h0020 + 16'(i), 16'h1000 + 16'(i), 2'b11);
    for (int i = 0; i < 4; i++) do_write(16'h0020 + 16'(i), 16'h1000 + 16'(i), 2'b11, 1'b0, -1, lat, bb);
    check("wf_full", 64'(WF_FULL), 64'd1);
    do_write(16'h0024, 16'h1004, 2'b11, 1'b0, 5, lat, bb);
    check("full_ack_lat", 64'(lat), 64'd7);
    wait_drained();

    // Overwrite-region writes and a partial byte-enable write, read back through the FB.
`ifdef S32X_FB_OVERWRITE_EN
    exp_push(16'h0040, 16'h00C3, 2'b01);
    do_write(16'h0040, 16'h00C3, 2'b11, 1'b1, -1, lat, bb);
    do_write(16'h0040, 16'h0000, 2'b11, 1'b1, -1, lat, bb);
    do_read(16'h0040, 16'h00C3, -1, lat, iss);
`else
    exp_push(16'h0040, 16'h00C3, 2'b11);
    exp_push(16'h0040, 16'h0000, 2'b11);
    do_write(16'h0040, 16'h00C3, 2'b11, 1'b1, -1, lat, bb);
    do_write(16'h0040, 16'h0000, 2'b11, 1'b1, -1, lat, bb);
    do_read(16'h0040, 16'h0000, -1, lat, iss);
`endif
    exp_push(16'h0041, 16'hBEEF, 2'b10);
    do_write(16'h0041, 16'hBEEF, 2'b10, 1'b0, -1, lat, bb);
    do_read(16'h0041, 16'hBE00, -1, lat, iss);
    tick();

    // A write requested during a 10-word fill waits until FILL_BUSY drops.
    for (int i = 0; i < 10; i++) exp_push(16'h3000 + 16'(i), 16'h5A5A, 2'b11);
    exp_push(16'h0050, 16'h7777, 2'b11);
    FILL_ADDR = 16'h3000; FILL_LEN = 8'd9; FILL_DATA = 16'h5A5A; FILL_START = 1'b1;
    tick();
    FILL_START = 1'b0;
    do_write(16'h0050, 16'h7777, 2'b11, 1'b0, -1, lat, bb);
    check("fillblk_busy_before_ack", 64'(bb), 64'd0);
    check("fillblk_stalled", 64'(lat >= 10), 64'd1);
    wait_drained();

    // Reset after the second word of an 8-word fill.
    exp_push(16'h4000, 16'h1234, 2'b11);
    exp_push(16'h4001, 16'h1234, 2'b11);
    FILL_ADDR = 16'h4000; FILL_LEN = 8'd7; FILL_DATA = 16'h1234; FILL_START = 1'b1;
    tick();
    FILL_START = 1'b0;
    n = 0;
    while (exp_wr.size() != 0 && n < 30) begin @(negedge CLK); #1; n++; end
    check("rstfill_two_words", 64'(exp_wr.size()), 64'd0);
    RST = 1'b1;
    #1;
    check_reset("rst_mid");
    tick(); tick();
    RST = 1'b0;
    repeat (20) tick();
    check("rstfill_busy_after", 64'(FILL_BUSY), 64'd0);
    check("rstfill_aout_after", 64'(FILL_AOUT), 64'd0);
    check("rstfill_wf_empty", 64'(WF_EMPTY), 64'd1);

    check("end_wr_queue", 64'(exp_wr.size()), 64'd0);
    check("end_rd_queue", 64'(exp_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
